// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word and the memory-arbiter state encoding.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;
endpackage

// File: rtl/memory_arbiter_sat_counter.sv
// 32-bit event counter with enable and synchronous clear; sticks at all-ones.
module sat_counter
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  logic  en,
  output word_t count
);
  word_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/memory_arbiter.sv
// Single RAM port shared between instruction fetch and data access; data wins ties.
// Optional stall counters are enabled with MEM_ARB_PERF_EN.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_rdy
`ifdef MEM_ARB_PERF_EN
  ,
  output word_t             icnt_stall,
  output word_t             dcnt_stall
`endif
);
  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;

  logic d_req;
  logic i_done, d_done;
  logic i_take, d_take;

  assign d_req  = dREN | dWEN;
  assign i_done = (state_q == IACC) & ram_rdy;
  assign d_done = (state_q == DACC) & ram_rdy;
  // A withdrawn request still finishes on the RAM, but its result is dropped.
  assign i_take = i_done & iREN;
  assign d_take = d_done & ~wr_q & d_req;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
        end else if (iREN) begin
          state_d = IACC;
          addr_d  = iaddr;
          wr_d    = 1'b0;
        end
      end
      IACC, DACC: begin
        if (ram_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_take) iload_d = ramload;
    if (d_take) dload_d = ramload;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  // RAM side is decoded purely from registered state so strobes cannot glitch.
  assign ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
  assign ramWEN   = (state_q == DACC) & wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  assign iwait = iREN & ~i_done;
  assign dwait = d_req & ~d_done;
  assign iload = i_take ? ramload : iload_q;
  assign dload = d_take ? ramload : dload_q;

`ifdef MEM_ARB_PERF_EN
  sat_counter u_icnt (
    .clk   (CLK),
    .clr   (RST),
    .en    (iwait),
    .count (icnt_stall)
  );

  sat_counter u_dcnt (
    .clk   (CLK),
    .clr   (RST),
    .en    (dwait),
    .count (dcnt_stall)
  );
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed plus random bench for memory_arbiter against a transaction-level model.
module tb_memory_arbiter;
  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_rdy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] icnt_stall;
  logic [31:0] dcnt_stall;
`endif

  int total = 0;
  int bad   = 0;

  // Model: at most one outstanding RAM transaction, described by its owner and op.
  bit          m_busy;
  bit          m_data;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  logic [31:0] m_iload;
  logic [31:0] m_dload;
  logic [31:0] m_icnt;
  logic [31:0] m_dcnt;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_rdy  (ram_rdy)
`ifdef MEM_ARB_PERF_EN
    ,
    .icnt_stall (icnt_stall),
    .dcnt_stall (dcnt_stall)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_data = 0; m_wr = 0;
    m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
    m_icnt = '0; m_dcnt = '0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic cycle(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] ds, input logic rdy, input logic [31:0] rl);
    bit          done_i, done_d, e_iwait, e_dwait;
    logic [31:0] e_iload, e_dload;
    @(negedge CLK);
    RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ram_rdy = rdy; ramload = rl;
    #1;
    done_i  = m_busy && !m_data && rdy;
    done_d  = m_busy && m_data && rdy;
    e_iwait = ir && !done_i;
    e_dwait = (dr || dw) && !done_d;
    e_iload = (done_i && ir) ? rl : m_iload;
    e_dload = (done_d && !m_wr && (dr || dw)) ? rl : m_dload;
    chk("ramREN",   {31'd0, ramREN},   {31'd0, m_busy && !(m_data && m_wr)});
    chk("ramWEN",   {31'd0, ramWEN},   {31'd0, m_busy && m_data && m_wr});
    chk("ramaddr",  ramaddr,  m_addr);
    chk("ramstore", ramstore, m_store);
    chk("iwait",    {31'd0, iwait},    {31'd0, e_iwait});
    chk("dwait",    {31'd0, dwait},    {31'd0, e_dwait});
    chk("iload",    iload,    e_iload);
    chk("dload",    dload,    e_dload);
`ifdef MEM_ARB_PERF_EN
    chk("icnt_stall", icnt_stall, m_icnt);
    chk("dcnt_stall", dcnt_stall, m_dcnt);
`endif
    if (rst) begin
      model_reset();
    end else begin
      if (e_iwait && m_icnt != 32'hFFFF_FFFF) m_icnt++;
      if (e_dwait && m_dcnt != 32'hFFFF_FFFF) m_dcnt++;
      if (m_busy) begin
        if (rdy) begin
          m_busy  = 0;
          m_iload = e_iload;
          m_dload = e_dload;
          $display("txn %s %s addr=%h data=%h%s", m_data ? "data" : "inst",
                   m_wr ? "wr" : "rd", m_addr, m_wr ? m_store : rl,
                   (m_data ? (dr || dw) : ir) ? "" : " (discarded)");
        end
      end else if (dr || dw) begin
        m_busy = 1; m_data = 1; m_wr = dw; m_addr = da; m_store = ds;
      end else if (ir) begin
        m_busy = 1; m_data = 0; m_wr = 0; m_addr = ia;
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rc, rd;
    model_reset();
    RST = 1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ram_rdy = 0; ramload = 0;

    // Reset held with a pending fetch, then release: fetch starts one cycle later.
    cycle(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h1111_1111);
    cycle(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h1111_1111);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 1, 32'h2408_0001);
    chk("pre_iacc_ramREN", {31'd0, ramREN}, 32'd0);
    cycle(0, 1, 32'h40, 0, 0, 0, 0, 1, 32'h2408_0001);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    chk("fetch_iload", iload, 32'h2408_0001);
    chk("fetch_iwait", {31'd0, iwait}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Simultaneous write and fetch: data in cycle 1, instruction in cycle 3.
    cycle(0, 1, 32'h200, 0, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'h5);
    cycle(0, 1, 32'h200, 0, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'h5);
    chk("sim_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("sim_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("sim_dwait", {31'd0, dwait}, 32'd0);
    cycle(0, 1, 32'h200, 0, 0, 0, 0, 1, 32'h6);
    cycle(0, 1, 32'h200, 0, 0, 0, 0, 1, 32'h0C00_0010);
    chk("sim_ramaddr", ramaddr, 32'h200);
    chk("sim_iwait", {31'd0, iwait}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Read with three RAM wait cycles, counted from a fresh reset.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, 32'h300, 0, 0, 32'hBAD0_0000);
      chk("stall_ramaddr", ramaddr, 32'h300);
      chk("stall_dwait", {31'd0, dwait}, 32'd1);
    end
    cycle(0, 0, 0, 1, 0, 32'h300, 0, 1, 32'hCAFE_F00D);
    chk("stall_dload", dload, 32'hCAFE_F00D);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_ARB_PERF_EN
    chk("stall_count", dcnt_stall, 32'd4);
`endif

    // Read withdrawn after grant: result discarded.
    cycle(0, 0, 0, 1, 0, 32'h310, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    chk("withdraw_dload", dload, 32'hCAFE_F00D);
    chk("withdraw_dwait", {31'd0, dwait}, 32'd0);

    // Reset during a stalled write.
    cycle(0, 0, 0, 0, 1, 32'h320, 32'h1234_5678, 0, 0);
    cycle(1, 0, 0, 0, 1, 32'h320, 32'h1234_5678, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_ramWEN", {31'd0, ramWEN}, 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("rst_mid_dcnt", dcnt_stall, 32'd0);
    chk("rst_mid_icnt", icnt_stall, 32'd0);
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), ra,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rb, rc,
            ($urandom_range(0, 2) != 0), rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
